// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one registered memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN to replace fixed data-first priority with round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          imem_req_i,
  input  logic [AW-1:0] imem_addr_i,
  output logic          imem_refused_o,
  output logic [DW-1:0] imem_rdata_o,
  input  logic          dmem_req_i,
  input  logic          dmem_wen_i,
  input  logic [AW-1:0] dmem_addr_i,
  input  logic [DW-1:0] dmem_wdata_i,
  output logic          dmem_refused_o,
  output logic [DW-1:0] dmem_rdata_o,
  output logic          mem_req_o,
  output logic          mem_wen_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t r_state;
  logic   w_grant_d;
  logic   w_done_i;
  logic   w_done_d;

`ifdef MEM_ARB_RR_EN
  // r_prefer_d=1 means the fetch side won last, so data is preferred on the next tie
  logic r_prefer_d;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_prefer_d <= 1'b0;
    end else if (r_state == S_IDLE && (imem_req_i || dmem_req_i)) begin
      r_prefer_d <= ~w_grant_d;
    end
  end

  assign w_grant_d = dmem_req_i & (~imem_req_i | r_prefer_d);
`else
  assign w_grant_d = dmem_req_i;
`endif

  assign w_done_i       = mem_ack_i & (r_state == S_BUSY_I);
  assign w_done_d       = mem_ack_i & (r_state == S_BUSY_D);
  assign imem_refused_o = imem_req_i & ~w_done_i;
  assign dmem_refused_o = dmem_req_i & ~w_done_d;
  assign imem_rdata_o   = mem_rdata_i;
  assign dmem_rdata_o   = mem_rdata_i;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      mem_req_o   <= 1'b0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            mem_req_o   <= 1'b1;
            mem_wen_o   <= dmem_wen_i;
            mem_addr_o  <= dmem_addr_i;
            mem_wdata_o <= dmem_wdata_i;
            r_state     <= S_BUSY_D;
          end else if (imem_req_i) begin
            mem_req_o   <= 1'b1;
            mem_wen_o   <= 1'b0;
            mem_addr_o  <= imem_addr_i;
            mem_wdata_o <= '0;
            r_state     <= S_BUSY_I;
          end else begin
            mem_req_o <= 1'b0;
          end
        end
        // Fields stay latched until the memory acknowledges; the owner dropping its request does not abort
        S_BUSY_I, S_BUSY_D: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected memory-port transactions queued at stimulus time, checked on grant.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 17;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          imem_req_i, dmem_req_i, dmem_wen_i, mem_ack_i;
  logic [AW-1:0] imem_addr_i, dmem_addr_i;
  logic [DW-1:0] dmem_wdata_i, mem_rdata_i;
  logic          imem_refused_o, dmem_refused_o, mem_req_o, mem_wen_o;
  logic [DW-1:0] imem_rdata_o, dmem_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic d_first;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_i(reset_i),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
    .imem_refused_o(imem_refused_o), .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_wen_i(dmem_wen_i), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_refused_o(dmem_refused_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_d();
    sb_q.push_back('{wen: dmem_wen_i, addr: dmem_addr_i, wdata: dmem_wdata_i});
  endtask

  task automatic push_i();
    sb_q.push_back('{wen: 1'b0, addr: imem_addr_i, wdata: '0});
  endtask

  task automatic sb_check(input string tag);
    txn_t t;
    chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
    total++;
    assert (sb_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      t = sb_q.pop_front();
      chk({tag, "_addr"},  32'(mem_addr_o),  32'(t.addr));
      chk({tag, "_wen"},   32'(mem_wen_o),   32'(t.wen));
      chk({tag, "_wdata"}, 32'(mem_wdata_o), 32'(t.wdata));
    end
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    d_first = 1'b0;
`else
    d_first = 1'b1;
`endif
    reset_i = 1'b1; imem_req_i = 1'b0; dmem_req_i = 1'b0; dmem_wen_i = 1'b0;
    imem_addr_i = '0; dmem_addr_i = '0; dmem_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    tick();
    // requests are refused and not accepted under reset
    imem_req_i = 1'b1; imem_addr_i = 12'h0AA;
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_irefused", 32'(imem_refused_o), 32'd1);
    tick();
    chk("rst_hold_req", 32'(mem_req_o), 32'd0);
    imem_req_i = 1'b0; reset_i = 1'b0;

    // single load with ack two cycles after request rises
    tick();
    dmem_req_i = 1'b1; dmem_wen_i = 1'b0; dmem_addr_i = 12'h01A; dmem_wdata_i = '0; push_d();
    #1 chk("ld_ref0", 32'(dmem_refused_o), 32'd1);
    tick();
    sb_check("ld");
    chk("ld_ref1", 32'(dmem_refused_o), 32'd1);
    tick();
    chk("ld_ref2", 32'(dmem_refused_o), 32'd1);
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 17'h1ABCD;
    #1 chk("ld_ref3", 32'(dmem_refused_o), 32'd0);
    chk("ld_rdata", 32'(dmem_rdata_o), 32'h1ABCD);
    tick();
    dmem_req_i = 1'b0; mem_ack_i = 1'b0;
    chk("ld_end_req", 32'(mem_req_o), 32'd0);
    chk("ld_end_addr", 32'(mem_addr_o), 32'h01A);

    // store with immediate ack
    tick();
    dmem_req_i = 1'b1; dmem_wen_i = 1'b1; dmem_addr_i = 12'h3FF; dmem_wdata_i = 17'h00055; push_d();
    tick();
    sb_check("st");
    mem_ack_i = 1'b1;
    #1 chk("st_ref", 32'(dmem_refused_o), 32'd0);
    tick();
    dmem_req_i = 1'b0; dmem_wen_i = 1'b0; dmem_wdata_i = '0; mem_ack_i = 1'b0;
    chk("st_end_req", 32'(mem_req_o), 32'd0);

    // simultaneous fetch and load
    tick();
    imem_req_i = 1'b1; imem_addr_i = 12'h100;
    dmem_req_i = 1'b1; dmem_addr_i = 12'h200;
    if (d_first) begin push_d(); push_i(); end
    else begin push_i(); push_d(); end
    tick();
    sb_check("sim1");
    mem_ack_i = 1'b1;
    #1 chk("sim1_dref", 32'(dmem_refused_o), d_first ? 32'd0 : 32'd1);
    chk("sim1_iref", 32'(imem_refused_o), d_first ? 32'd1 : 32'd0);
    tick();
    if (d_first) dmem_req_i = 1'b0; else imem_req_i = 1'b0;
    mem_ack_i = 1'b0;
    chk("sim_gap_req", 32'(mem_req_o), 32'd0);
    tick();
    sb_check("sim2");
    mem_ack_i = 1'b1;
    #1 chk("sim2_ref", 32'(d_first ? imem_refused_o : dmem_refused_o), 32'd0);
    tick();
    imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_ack_i = 1'b0;

    // data request arriving during an in-flight fetch waits its turn
    tick();
    imem_req_i = 1'b1; imem_addr_i = 12'h0AA; push_i();
    tick();
    sb_check("mid_i");
    dmem_req_i = 1'b1; dmem_addr_i = 12'h0BB;
    #1 chk("mid_dref0", 32'(dmem_refused_o), 32'd1);
    tick();
    chk("mid_addr", 32'(mem_addr_o), 32'h0AA);
    mem_ack_i = 1'b1;
    #1 chk("mid_iref", 32'(imem_refused_o), 32'd0);
    chk("mid_dref1", 32'(dmem_refused_o), 32'd1);
    tick();
    imem_req_i = 1'b0; mem_ack_i = 1'b0; push_d();
    chk("mid_gap_req", 32'(mem_req_o), 32'd0);
    tick();
    sb_check("mid_d");
    mem_ack_i = 1'b1;
    #1 chk("mid_dref2", 32'(dmem_refused_o), 32'd0);
    tick();
    dmem_req_i = 1'b0; mem_ack_i = 1'b0;

    // asynchronous reset pulse while data owns the port
    tick();
    dmem_req_i = 1'b1; dmem_addr_i = 12'h123; push_d();
    tick();
    sb_check("ar_pre");
    #2 reset_i = 1'b1; mem_ack_i = 1'b1;
    #1 chk("ar_req", 32'(mem_req_o), 32'd0);
    chk("ar_addr", 32'(mem_addr_o), 32'd0);
    chk("ar_dref", 32'(dmem_refused_o), 32'd1);
    #1 reset_i = 1'b0; mem_ack_i = 1'b0; push_d();
    tick();
    sb_check("ar_post");
    mem_ack_i = 1'b1;
    #1 chk("ar_post_ref", 32'(dmem_refused_o), 32'd0);
    tick();
    dmem_req_i = 1'b0; mem_ack_i = 1'b0;

    // stray ack in idle is ignored
    tick();
    mem_ack_i = 1'b1;
    #1 chk("idle_iref", 32'(imem_refused_o), 32'd0);
    chk("idle_dref", 32'(dmem_refused_o), 32'd0);
    tick();
    chk("idle_req", 32'(mem_req_o), 32'd0);
    chk("idle_addr", 32'(mem_addr_o), 32'h123);
    mem_ack_i = 1'b0;
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 12: width of a memory word address.
REQ-002 Parameter DW, default 17: width of a memory data word.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 imem_req_i  input  1  instruction-fetch read request; held until accepted.
REQ-006 imem_addr_i  input  AW  fetch address; stable while imem_req_i=1.
REQ-007 imem_refused_o  output  1  fetch not complete this cycle.
REQ-008 imem_rdata_o  output  DW  fetch data; valid when imem_req_i=1 and imem_refused_o=0.
REQ-009 dmem_req_i  input  1  backend data request; held until completed.
REQ-010 dmem_wen_i  input  1  1=store, 0=load; stable while dmem_req_i=1.
REQ-011 dmem_addr_i  input  AW  data address.
REQ-012 dmem_wdata_i  input  DW  store data.
REQ-013 dmem_refused_o  output  1  data access not complete this cycle.
REQ-014 dmem_rdata_o  output  DW  load data; valid when dmem_req_i=1 and dmem_refused_o=0.
REQ-015 mem_req_o  output  1  shared memory port request, registered.
REQ-016 mem_wen_o  output  1  shared port write enable, registered.
REQ-017 mem_addr_o  output  AW  shared port address, registered.
REQ-018 mem_wdata_o  output  DW  shared port write data, registered.
REQ-019 mem_ack_i  input  1  memory completes the current access this cycle.
REQ-020 mem_rdata_i  input  DW  read data, valid with mem_ack_i.

Function
REQ-021 FSM states: sIdle, sBusyI (fetch owns port), sBusyD (data owns port).
REQ-022 In sIdle with any request: latch winner's addr/wen/wdata onto mem_* outputs, set mem_req_o=1, go to sBusyI/sBusyD at next edge.
REQ-023 Imem accesses always drive mem_wen_o=0 and mem_wdata_o=0.
REQ-024 In sIdle with no request: mem_req_o=0, other mem_* outputs hold their values.
REQ-025 In sBusyX: mem_req_o and latched fields stay constant until a cycle with mem_ack_i=1.
REQ-026 At the edge ending an ack cycle: mem_req_o=0 and state returns to sIdle.
REQ-027 done_X = mem_ack_i & (state==sBusyX), combinational.
REQ-028 X_refused_o = X_req_i & ~done_X, combinational; refused_o is 0 whenever req_i=0.
REQ-029 imem_rdata_o and dmem_rdata_o are driven by mem_rdata_i combinationally.
REQ-030 Minimum latency: request in sIdle at cycle N, mem_req_o=1 at N+1, refused_o=0 at N+1 if mem_ack_i=1 at N+1.
REQ-031 Back-to-back accesses have at least one sIdle cycle between ack and next mem_req_o rise.
REQ-032 Both requests present in sIdle: dmem wins (fixed priority); the loser's refused_o stays 1.
REQ-033 A requester that drops req_i while owning the port: access still completes on mem_ack_i; no refused_o=0 is produced for it.
REQ-034 mem_ack_i in sIdle is ignored.

Reset
REQ-035 Assertion of reset_i immediately forces state=sIdle and mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o=0, independent of clk.
REQ-036 Reset during sBusyX abandons the in-flight access; no done is reported for it.
REQ-037 While reset_i=1: no request is accepted and X_refused_o=X_req_i.
REQ-038 With MEM_ARB_RR_EN defined, reset clears the round-robin pointer to "imem preferred".

Configuration
REQ-039 Macro MEM_ARB_RR_EN: when defined, simultaneous requests in sIdle go to the requester not granted most recently; the pointer updates at each grant.
REQ-040 Without MEM_ARB_RR_EN: fixed dmem priority per REQ-032, and no pointer register exists.

Verification
REQ-041 Single load: dmem_req_i=1, addr=0x01A, wen=0; ack two cycles after mem_req_o rises with rdata=0x1ABCD -> mem_addr_o=0x01A; dmem_refused_o=1,1,1 then 0 with dmem_rdata_o=0x1ABCD.
REQ-042 Store: dmem_wen_i=1, addr=0x3FF, wdata=0x00055, immediate ack -> mem_wen_o=1, mem_wdata_o=0x00055 for one cycle; dmem_refused_o=0 at cycle N+1.
REQ-043 Simultaneous fetch 0x100 and load 0x200, ack=1 every busy cycle -> default: dmem served first, imem next. MEM_ARB_RR_EN after reset: imem first, then dmem.
REQ-044 Fetch in progress, dmem_req_i rises mid-access -> mem_addr_o unchanged; dmem_refused_o=1 until its own ack.
REQ-045 reset_i pulsed mid-sBusyD without a clk edge -> mem_req_o=0 immediately, state sIdle, held dmem_req_i re-accepted after reset_i falls.
REQ-046 mem_ack_i=1 in sIdle with no requests -> no output changes, both refused_o=0.
